jtframe_6801timer: RTL and testbench

JTFRAME_6801TIMER -- requirements
Module: jtframe_6801timer

---
 rtl/jtframe_6801timer.sv | 139 +++++++++++++
 tb/tb_jtframe_6801timer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_6801timer.sv
// MC6801 programmable timer: free-running counter, output compare,
// input capture and the TCSR flag/interrupt logic.
module jtframe_6801timer #(
  parameter int SYNC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cs,
  input  logic [4:0] addr,
  input  logic       wrn,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       tin,
  output logic       tout,
  output logic       irq_icf,
  output logic       irq_ocf,
  output logic       irq_tof
);

  logic [15:0] frc, ocr, icr;
  logic [4:0]  ctrl;
  logic        icf, ocf, tof;
  logic        seen_icf, seen_ocf, seen_tof;
  logic [7:0]  lsb;
  logic        lsb_vld;
  logic        tin_s, tin_l, pend;
  logic        edge_det, cap, cmp;
  logic        rd, wr;
  logic        rd_tcsr, rd_frch, rd_frcl, rd_icrh;
  logic        wr_tcsr, wr_frch, wr_ocrh, wr_ocrl;
  logic        set_icf, set_ocf, set_tof;
  logic        clr_icf, clr_ocf, clr_tof;

  generate
    if (SYNC != 0) begin : g_sync
      logic [1:0] ff;
      always_ff @(posedge clk) begin
        if (rst) ff <= '0;
        else     ff <= {ff[0], tin};
      end
      assign tin_s = ff[1];
    end else begin : g_nosync
      assign tin_s = tin;
    end
  endgenerate

  assign rd = cs & cen & wrn;
  assign wr = cs & cen & ~wrn;

  assign rd_tcsr = rd && addr == 5'h08;
  assign rd_frch = rd && addr == 5'h09;
  assign rd_frcl = rd && addr == 5'h0A;
  assign rd_icrh = rd && addr == 5'h0D;
  assign wr_tcsr = wr && addr == 5'h08;
  assign wr_frch = wr && addr == 5'h09;
  assign wr_ocrh = wr && addr == 5'h0B;
  assign wr_ocrl = wr && addr == 5'h0C;

  assign edge_det = ctrl[1] ? (tin_s & ~tin_l) : (~tin_s & tin_l);
  assign cap      = cen & (pend | edge_det);
  assign cmp      = (frc == ocr) & ~(wr_ocrh | wr_ocrl);

  assign set_icf = cap;
  assign set_ocf = cmp;
  assign set_tof = ~wr_frch & (frc == 16'hFFFF);
  assign clr_icf = rd_icrh & seen_icf;
  assign clr_ocf = (wr_ocrh | wr_ocrl) & seen_ocf;
  assign clr_tof = rd_frch & seen_tof;

  // Edges seen between E cycles wait here for the next cen
  always_ff @(posedge clk) begin
    if (rst) begin
      tin_l <= 1'b0;
      pend  <= 1'b0;
    end else begin
      tin_l <= tin_s;
      if (cen)           pend <= 1'b0;
      else if (edge_det) pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frc      <= 16'h0000;
      ocr      <= 16'hFFFF;
      icr      <= 16'h0000;
      ctrl     <= 5'd0;
      icf      <= 1'b0;
      ocf      <= 1'b0;
      tof      <= 1'b0;
      seen_icf <= 1'b0;
      seen_ocf <= 1'b0;
      seen_tof <= 1'b0;
      lsb      <= 8'd0;
      lsb_vld  <= 1'b0;
      tout     <= 1'b0;
    end else if (cen) begin
      frc <= wr_frch ? 16'hFFF8 : frc + 16'd1;
      if (wr_ocrh) ocr[15:8] <= din;
      if (wr_ocrl) ocr[7:0]  <= din;
      if (cap)     icr <= frc;
      if (wr_tcsr) ctrl <= din[4:0];
      if (cmp)     tout <= ctrl[0];
      if (rd_frch) begin
        lsb     <= frc[7:0];
        lsb_vld <= 1'b1;
      end else if (rd_frcl) begin
        lsb_vld <= 1'b0;
      end
      // A set wins over a clear; the seen bit still drops
      icf      <= set_icf | (icf & ~clr_icf);
      ocf      <= set_ocf | (ocf & ~clr_ocf);
      tof      <= set_tof | (tof & ~clr_tof);
      seen_icf <= ~clr_icf & (seen_icf | (rd_tcsr & icf));
      seen_ocf <= ~clr_ocf & (seen_ocf | (rd_tcsr & ocf));
      seen_tof <= ~clr_tof & (seen_tof | (rd_tcsr & tof));
    end
  end

  always_comb begin
    dout = 8'hFF;
    case (addr)
      5'h08:   dout = {icf, ocf, tof, ctrl};
      5'h09:   dout = frc[15:8];
      5'h0A:   dout = lsb_vld ? lsb : frc[7:0];
      5'h0B:   dout = ocr[15:8];
      5'h0C:   dout = ocr[7:0];
      5'h0D:   dout = icr[15:8];
      5'h0E:   dout = icr[7:0];
      default: dout = 8'hFF;
    endcase
  end

  assign irq_icf = icf & ctrl[4];
  assign irq_ocf = ocf & ctrl[3];
  assign irq_tof = tof & ctrl[2];

endmodule

// File: tb/tb_jtframe_6801timer.sv
// Scoreboard bench for jtframe_6801timer: directed bus/tin stimulus,
// expectations queued and checked by a negedge monitor.
module tb_jtframe_6801timer;

  logic       clk = 1'b0;
  logic       rst, cen, cs, wrn, tin;
  logic [4:0] addr;
  logic [7:0] din, dout;
  logic       tout, irq_icf, irq_ocf, irq_tof;

  localparam int S_DOUT = 0;
  localparam int S_TOUT = 1;
  localparam int S_IRQ  = 2;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } item_t;

  item_t q[$];
  item_t it;
  logic [7:0] act;
  int n_chk  = 0;
  int n_fail = 0;

  jtframe_6801timer #(.SYNC(1)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cs(cs), .addr(addr),
    .wrn(wrn), .din(din), .dout(dout), .tin(tin), .tout(tout),
    .irq_icf(irq_icf), .irq_ocf(irq_ocf), .irq_tof(irq_tof)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      it = q.pop_front();
      case (it.sel)
        S_DOUT:  act = dout;
        S_TOUT:  act = {7'd0, tout};
        default: act = {5'd0, irq_icf, irq_ocf, irq_tof};
      endcase
      n_chk++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", it.tag, act, it.exp);
      end
    end
  end

  task automatic push(input string tag, input int sel,
                      input logic [7:0] e);
    item_t x;
    x.tag = tag;
    x.sel = sel;
    x.exp = e;
    q.push_back(x);
  endtask

  task automatic peek(input string tag, input logic [4:0] a,
                      input logic [7:0] e);
    cs = 0; cen = 0; addr = a;
    push(tag, S_DOUT, e);
    @(posedge clk); #1;
  endtask

  task automatic obs(input string tag, input int sel,
                     input logic [7:0] e);
    cs = 0; cen = 0;
    push(tag, sel, e);
    @(posedge clk); #1;
  endtask

  task automatic tick(input int n);
    cen = 1;
    repeat (n) @(posedge clk);
    #1 cen = 0;
  endtask

  task automatic idle(input int n);
    cen = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    cs = 1; wrn = 0; addr = a; din = d; cen = 1;
    @(posedge clk); #1;
    cs = 0; wrn = 1; cen = 0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a,
                    input logic [7:0] e);
    cs = 1; wrn = 1; addr = a; cen = 1;
    push(tag, S_DOUT, e);
    @(posedge clk); #1;
    cs = 0; cen = 0;
  endtask

  initial begin
    rst = 1; cs = 1; wrn = 0; addr = 5'h08; din = 8'h1F;
    cen = 1; tin = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0; cs = 0; wrn = 1; cen = 0; tin = 0;

    peek("rst_tcsr", 5'h08, 8'h00);
    peek("rst_frch", 5'h09, 8'h00);
    peek("rst_frcl", 5'h0A, 8'h00);
    peek("rst_ocrh", 5'h0B, 8'hFF);
    peek("rst_ocrl", 5'h0C, 8'hFF);
    peek("rst_icrh", 5'h0D, 8'h00);
    peek("rst_icrl", 5'h0E, 8'h00);
    peek("unmapped", 5'h1F, 8'hFF);
    obs("rst_irq", S_IRQ, 8'h00);
    obs("rst_tout", S_TOUT, 8'h00);

    // Full wrap; OCR=FFFF at reset also matches on the last count
    tick(65535);
    peek("pre_wrap_tcsr", 5'h08, 8'h00);
    peek("ffff_h", 5'h09, 8'hFF);
    peek("ffff_l", 5'h0A, 8'hFF);
    tick(1);
    peek("wrap_tcsr", 5'h08, 8'h60);
    peek("wrap_frch", 5'h09, 8'h00);
    obs("wrap_tout", S_TOUT, 8'h00);
    wr(5'h08, 8'h04);
    obs("irq_tof", S_IRQ, 8'h01);
    peek("etoi_tcsr", 5'h08, 8'h64);
    rd("rd_tcsr1", 5'h08, 8'h64);
    rd("rd_frch_clr", 5'h09, 8'h00);
    peek("tof_clr", 5'h08, 8'h44);
    obs("tof_irq_off", S_IRQ, 8'h00);
    peek("buf_peek", 5'h0A, 8'h02);
    rd("rd_frcl_buf", 5'h0A, 8'h02);
    peek("frcl_live", 5'h0A, 8'h04);

    // Coherent 16-bit read across a low-byte rollover
    tick(4859);
    peek("12ff_h", 5'h09, 8'h12);
    peek("12ff_l", 5'h0A, 8'hFF);
    rd("coh_h", 5'h09, 8'h12);
    tick(5);
    rd("coh_l", 5'h0A, 8'hFF);
    peek("after_h", 5'h09, 8'h13);
    peek("after_l", 5'h0A, 8'h06);

    // Output compare at 0010
    wr(5'h0B, 8'h00);
    wr(5'h0C, 8'h10);
    wr(5'h08, 8'h09);
    peek("ocf_clr_seen", 5'h08, 8'h09);
    peek("ocr_l", 5'h0C, 8'h10);
    wr(5'h09, 8'h00);
    peek("preset_h", 5'h09, 8'hFF);
    peek("preset_l", 5'h0A, 8'hF8);
    tick(8);
    tick(16);
    peek("pre_cmp", 5'h08, 8'h29);
    obs("pre_cmp_tout", S_TOUT, 8'h00);
    tick(1);
    peek("cmp_tcsr", 5'h08, 8'h69);
    obs("cmp_tout", S_TOUT, 8'h01);
    obs("cmp_irq", S_IRQ, 8'h02);
    wr(5'h0C, 8'h10);
    peek("ocf_no_seen", 5'h08, 8'h69);
    rd("rd_tcsr2", 5'h08, 8'h69);
    wr(5'h0C, 8'h10);
    peek("ocf_clr", 5'h08, 8'h29);
    obs("ocf_irq_off", S_IRQ, 8'h00);
    obs("tout_hold", S_TOUT, 8'h01);

    // TOF set collides with its clearing read
    wr(5'h09, 8'h00);
    tick(7);
    rd("coll_h", 5'h09, 8'hFF);
    peek("coll_tcsr", 5'h08, 8'h29);
    rd("seen_gone", 5'h09, 8'h00);
    peek("seen_gone_tcsr", 5'h08, 8'h29);
    rd("drop_buf", 5'h0A, 8'h00);

    // Input capture, rising edge, through the synchroniser
    wr(5'h08, 8'h12);
    tick(4657);
    peek("olvl0_tcsr", 5'h08, 8'h72);
    obs("olvl0_tout", S_TOUT, 8'h00);
    tin = 1;
    tick(3);
    peek("icr_h", 5'h0D, 8'h12);
    peek("icr_l", 5'h0E, 8'h36);
    peek("icf_tcsr", 5'h08, 8'hF2);
    obs("icf_irq", S_IRQ, 8'h04);
    rd("icr_no_seen", 5'h0D, 8'h12);
    peek("icf_kept", 5'h08, 8'hF2);
    rd("rd_tcsr3", 5'h08, 8'hF2);
    rd("icr_clr", 5'h0D, 8'h12);
    peek("icf_clr", 5'h08, 8'h72);
    obs("icf_irq_off", S_IRQ, 8'h00);
    tin = 0;
    tick(4);
    peek("fall_tcsr", 5'h08, 8'h72);
    peek("fall_icr_l", 5'h0E, 8'h36);
    tin = 1;
    idle(4);
    tick(1);
    peek("pend_icr_h", 5'h0D, 8'h12);
    peek("pend_icr_l", 5'h0E, 8'h3E);
    peek("pend_tcsr", 5'h08, 8'hF2);

    // Reset overrides a concurrent TCSR write
    rst = 1; cs = 1; wrn = 0; addr = 5'h08; din = 8'h1F;
    cen = 1; tin = 0;
    @(posedge clk); #1;
    rst = 0; cs = 0; wrn = 1; cen = 0;
    peek("rst2_tcsr", 5'h08, 8'h00);
    peek("rst2_frch", 5'h09, 8'h00);
    peek("rst2_ocrh", 5'h0B, 8'hFF);
    peek("rst2_icrl", 5'h0E, 8'h00);
    obs("rst2_irq", S_IRQ, 8'h00);

    idle(2);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
